// File: rtl/division_booth_inversa_if.sv
// Start/result bundle for division_booth_inversa.
// The master drives operands; the slave returns the result.
interface division_booth_inversa_if #(
   parameter int N = 8
);
   logic           valid;
   logic [2*N-1:0] Dvd;
   logic [N-1:0]   Dvs;
   logic [N-1:0]   Quot;
   logic [N-1:0]   Rem;
   logic           ovf;
   logic           dz;
   logic           busy;
   logic           done;

   modport master (
      output valid, Dvd, Dvs,
      input  Quot, Rem, ovf, dz, busy, done
   );

   modport slave (
      input  valid, Dvd, Dvs,
      output Quot, Rem, ovf, dz, busy, done
   );
endinterface

// File: rtl/division_booth_inversa.sv
// Sequential signed restoring divider: 2N/N -> N quotient and remainder.
// Define DIV_REM_EN to compute the signed remainder; otherwise Rem is 0.
module division_booth_inversa #(
   parameter int N = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   division_booth_inversa_if.slave bus
);
   localparam int CW = $clog2(2*N+1);
   localparam logic [2*N-1:0] MAXP = (2*N)'((2**(N-1))-1);
   localparam logic [2*N-1:0] MAXN = (2*N)'(2**(N-1));
   localparam logic [N-1:0]   QMAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]   QMIN = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIVIDE,
      FIX,
      DONE
   } state_t;

   state_t         state_q;
   logic [2*N-1:0] dvd_q;
   logic [N-1:0]   dvs_q;
   logic [2*N-1:0] dq_q;
   logic [N:0]     pr_q;
   logic [N:0]     mdvs_q;
   logic [CW-1:0]  cnt_q;
   logic           sq_q;
   logic [N-1:0]   quot_q;
   logic           ovf_q;
   logic           dz_q;
   logic           busy_q;
   logic           done_q;

   logic [2*N-1:0] abs_dvd;
   logic [N:0]     abs_dvs;
   logic [N+1:0]   sh_pr;
   logic           ge;
   logic [N:0]     pr_d;
   logic           ovf_hit;
   logic [N-1:0]   quot_d;

   always_comb begin
      abs_dvd = dvd_q[2*N-1] ? (~dvd_q + 1'b1) : dvd_q;
      abs_dvs = dvs_q[N-1] ? (~{1'b1, dvs_q} + 1'b1)
                           : {1'b0, dvs_q};
      // PR never exceeds |Dvs|-1, so the shifted value fits N+1 bits
      sh_pr   = {pr_q, dq_q[2*N-1]};
      ge      = (sh_pr >= {1'b0, mdvs_q});
      pr_d    = ge ? (N+1)'(sh_pr - {1'b0, mdvs_q})
                   : (N+1)'(sh_pr);
      ovf_hit = sq_q ? (dq_q > MAXN) : (dq_q > MAXP);
      quot_d  = sq_q ? (~dq_q[N-1:0] + 1'b1) : dq_q[N-1:0];
   end

`ifdef DIV_REM_EN
   logic         sr_q;
   logic [N-1:0] rem_q;
   logic [N-1:0] rem_d;

   always_comb begin
      rem_d = sr_q ? (~pr_q[N-1:0] + 1'b1) : pr_q[N-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= 1'b0;
         rem_q <= '0;
      end else begin
         unique case (state_q)
            LOAD: begin
               sr_q <= dvd_q[2*N-1];
               if (dvs_q == '0) rem_q <= '0;
            end
            FIX: rem_q <= ovf_hit ? '0 : rem_d;
            default: ;
         endcase
      end
   end

   assign bus.Rem = rem_q;
`else
   assign bus.Rem = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         dq_q    <= '0;
         pr_q    <= '0;
         mdvs_q  <= '0;
         cnt_q   <= '0;
         sq_q    <= 1'b0;
         quot_q  <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.valid) begin
                  dvd_q   <= bus.Dvd;
                  dvs_q   <= bus.Dvs;
                  ovf_q   <= 1'b0;
                  dz_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               sq_q   <= dvd_q[2*N-1] ^ dvs_q[N-1];
               dq_q   <= abs_dvd;
               mdvs_q <= abs_dvs;
               pr_q   <= '0;
               cnt_q  <= CW'(2*N);
               if (dvs_q == '0) begin
                  quot_q  <= dvd_q[2*N-1] ? QMIN : QMAX;
                  ovf_q   <= 1'b0;
                  dz_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= DIVIDE;
               end
            end
            DIVIDE: begin
               pr_q  <= pr_d;
               dq_q  <= {dq_q[2*N-2:0], ge};
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) state_q <= FIX;
            end
            FIX: begin
               if (ovf_hit) begin
                  quot_q <= sq_q ? QMIN : QMAX;
                  ovf_q  <= 1'b1;
               end else begin
                  quot_q <= quot_d;
                  ovf_q  <= 1'b0;
               end
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.Quot = quot_q;
   assign bus.ovf  = ovf_q;
   assign bus.dz   = dz_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule
